// File: rtl/rs_issue_queue.sv
// Reservation station for the integer execution unit. Holds dispatched instructions
// until both operands are resolved and issues the lowest-index ready entry each cycle.
module rs_issue_queue #(
  parameter int DEPTH = 8,
  parameter int DW    = 16,
  parameter int TW    = 5,
  parameter int OPW   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     disp_valid,
  output logic                     disp_ready,
  input  logic [OPW-1:0]           disp_op,
  input  logic [TW-1:0]            disp_rob_tag,
  input  logic [4:0]               disp_dest,
  input  logic                     disp_a_rdy,
  input  logic [DW-1:0]            disp_a_val,
  input  logic [TW-1:0]            disp_a_tag,
  input  logic                     disp_b_rdy,
  input  logic [DW-1:0]            disp_b_val,
  input  logic [TW-1:0]            disp_b_tag,
  input  logic                     cdb_valid,
  input  logic [TW-1:0]            cdb_tag,
  input  logic [DW-1:0]            cdb_data,
  output logic                     iss_valid,
  input  logic                     iss_ready,
  output logic [OPW-1:0]           iss_op,
  output logic [DW-1:0]            iss_a,
  output logic [DW-1:0]            iss_b,
  output logic [TW-1:0]            iss_rob_tag,
  output logic [4:0]               iss_dest,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  logic [DEPTH-1:0]          valid_q, valid_d, a_rdy_q, a_rdy_d, b_rdy_q, b_rdy_d;
  logic [DEPTH-1:0][OPW-1:0] op_q, op_d;
  logic [DEPTH-1:0][TW-1:0]  rob_q, rob_d, a_tag_q, a_tag_d, b_tag_q, b_tag_d;
  logic [DEPTH-1:0][4:0]     dest_q, dest_d;
  logic [DEPTH-1:0][DW-1:0]  a_val_q, a_val_d, b_val_q, b_val_d;
  logic [CW-1:0]             occupancy_q, occupancy_d;

  logic [DEPTH-1:0] issuable_s, iss_oh_s, wr_oh_s, wake_a_s, wake_b_s;
  logic [IW-1:0]    sel_idx_s, free_idx_s;
  logic             iss_fire_s, disp_acc_s, byp_a_s, byp_b_s;

  // Priority pick: lowest-index issuable entry and lowest-index free entry
  always_comb begin
    issuable_s = valid_q & a_rdy_q & b_rdy_q;
    sel_idx_s  = {IW{1'b0}};
    free_idx_s = {IW{1'b0}};
    for (int i = DEPTH - 1; i >= 0; i--) begin
      sel_idx_s  = issuable_s[i] ? IW'(i) : sel_idx_s;
      free_idx_s = !valid_q[i]   ? IW'(i) : free_idx_s;
    end
  end

  assign iss_valid   = |issuable_s;
  assign disp_ready  = (occupancy_q < CW'(DEPTH));
  assign iss_fire_s  = iss_valid & iss_ready;
  assign disp_acc_s  = disp_valid & disp_ready;
  assign iss_op      = iss_valid ? op_q[sel_idx_s]    : {OPW{1'b0}};
  assign iss_a       = iss_valid ? a_val_q[sel_idx_s] : {DW{1'b0}};
  assign iss_b       = iss_valid ? b_val_q[sel_idx_s] : {DW{1'b0}};
  assign iss_rob_tag = iss_valid ? rob_q[sel_idx_s]   : {TW{1'b0}};
  assign iss_dest    = iss_valid ? dest_q[sel_idx_s]  : 5'd0;
  assign occupancy   = occupancy_q;

  // A dispatched operand whose producer broadcasts in the same cycle is captured directly
  assign byp_a_s = !disp_a_rdy && cdb_valid && (cdb_tag == disp_a_tag);
  assign byp_b_s = !disp_b_rdy && cdb_valid && (cdb_tag == disp_b_tag);

  // Entry next-state: dispatch write, CDB wakeup, issue clear, flush
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      wake_a_s[i] = valid_q[i] && !a_rdy_q[i] && cdb_valid && (cdb_tag == a_tag_q[i]);
      wake_b_s[i] = valid_q[i] && !b_rdy_q[i] && cdb_valid && (cdb_tag == b_tag_q[i]);
      iss_oh_s[i] = iss_fire_s && (sel_idx_s == IW'(i));
      wr_oh_s[i]  = disp_acc_s && (free_idx_s == IW'(i));
      valid_d[i]  = flush ? 1'b0 : ((valid_q[i] & ~iss_oh_s[i]) | wr_oh_s[i]);
      if (wr_oh_s[i]) begin
        op_d[i]    = disp_op;
        rob_d[i]   = disp_rob_tag;
        dest_d[i]  = disp_dest;
        a_rdy_d[i] = disp_a_rdy | byp_a_s;
        a_val_d[i] = byp_a_s ? cdb_data : disp_a_val;
        a_tag_d[i] = disp_a_tag;
        b_rdy_d[i] = disp_b_rdy | byp_b_s;
        b_val_d[i] = byp_b_s ? cdb_data : disp_b_val;
        b_tag_d[i] = disp_b_tag;
      end else begin
        op_d[i]    = op_q[i];
        rob_d[i]   = rob_q[i];
        dest_d[i]  = dest_q[i];
        a_rdy_d[i] = a_rdy_q[i] | wake_a_s[i];
        a_val_d[i] = wake_a_s[i] ? cdb_data : a_val_q[i];
        a_tag_d[i] = a_tag_q[i];
        b_rdy_d[i] = b_rdy_q[i] | wake_b_s[i];
        b_val_d[i] = wake_b_s[i] ? cdb_data : b_val_q[i];
        b_tag_d[i] = b_tag_q[i];
      end
    end
  end

  // Occupancy tracks accepted dispatches minus completed issues
  always_comb begin
    case ({disp_acc_s, iss_fire_s})
      2'b10:   occupancy_d = occupancy_q + CW'(1);
      2'b01:   occupancy_d = occupancy_q - CW'(1);
      default: occupancy_d = occupancy_q;
    endcase
    if (flush) begin
      occupancy_d = {CW{1'b0}};
    end else begin
      occupancy_d = occupancy_d;
    end
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q     <= '0;
      a_rdy_q     <= '0;
      b_rdy_q     <= '0;
      op_q        <= '0;
      rob_q       <= '0;
      dest_q      <= '0;
      a_val_q     <= '0;
      a_tag_q     <= '0;
      b_val_q     <= '0;
      b_tag_q     <= '0;
      occupancy_q <= '0;
    end else begin
      valid_q     <= valid_d;
      a_rdy_q     <= a_rdy_d;
      b_rdy_q     <= b_rdy_d;
      op_q        <= op_d;
      rob_q       <= rob_d;
      dest_q      <= dest_d;
      a_val_q     <= a_val_d;
      a_tag_q     <= a_tag_d;
      b_val_q     <= b_val_d;
      b_tag_q     <= b_tag_d;
      occupancy_q <= occupancy_d;
    end
  end

endmodule
